// File: rtl/pcie_msi_irq_ctrl_pkg.sv
// Shared definitions for the PCIe MSI interrupt controller: FSM states and the
// vector fold helper that maps a source index onto the allocated MSI vectors.
package pcie_msi_irq_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StGap  = 2'd2
  } msi_state_e;

  localparam int unsigned MSI_MAX_VECTORS = 32;
  localparam int unsigned SRC_W           = 5;

  // MMEnable n allocates 2^n vectors; 6 and 7 are reserved and treated as one vector.
  function automatic logic [SRC_W-1:0] fold_vector(input logic [SRC_W-1:0] src,
                                                    input logic [2:0]       mmenable);
    logic [5:0] nvec;
    nvec = (mmenable <= 3'd5) ? (6'd1 << mmenable) : 6'd1;
    if ({1'b0, src} < nvec) begin
      return src;
    end
    return SRC_W'(nvec - 6'd1);
  endfunction

endpackage

// File: rtl/pcie_msi_irq_ctrl_rr_arb.sv
// Combinational round-robin pick: first requesting index after the last-granted
// pointer, wrapping modulo NUM_IRQ.
module pcie_msi_irq_ctrl_rr_arb
  import pcie_msi_irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] i_req,
  input  logic [SRC_W-1:0]   i_last,
  output logic               o_valid,
  output logic [SRC_W-1:0]   o_idx
);

  int unsigned w_best;
  int unsigned w_dist;

  // Distance of index i from the slot right after i_last; smallest distance wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_best  = NUM_IRQ;
    w_dist  = 0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (i_req[i]) begin
        w_dist = (i + NUM_IRQ - 1 - 32'(i_last)) % NUM_IRQ;
        if (w_dist < w_best) begin
          w_best  = w_dist;
          o_idx   = SRC_W'(i);
          o_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pcie_msi_irq_ctrl.sv
// Collects user interrupt lines, latches rising edges and drives the endpoint's
// MSI request/grant handshake with one outstanding request and optional holdoff.
module pcie_msi_irq_ctrl
  import pcie_msi_irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ        = 8,
  parameter int unsigned HOLDOFF_CYCLES = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_IRQ-1:0] i_irq_in,
  input  logic [NUM_IRQ-1:0] i_irq_mask,
  input  logic               i_msi_enable,
  input  logic [2:0]         i_msi_vector_width,
  input  logic               i_intx_msi_grant,
  output logic               o_intx_msi_request,
  output logic [4:0]         o_msi_vector_num,
  output logic [NUM_IRQ-1:0] o_irq_pending,
  output logic               o_irq_sent,
  output logic [4:0]         o_irq_sent_src
);

  localparam logic [SRC_W-1:0] RrInit   = SRC_W'(NUM_IRQ - 1);
  localparam logic [15:0]      HoldLoad = (HOLDOFF_CYCLES == 0) ? 16'd0
                                                                : 16'(HOLDOFF_CYCLES - 1);

  msi_state_e         r_state,    w_state_nxt;
  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_pending,  w_pending_nxt;
  logic               r_request,  w_request_nxt;
  logic [SRC_W-1:0]   r_vector,   w_vector_nxt;
  logic [SRC_W-1:0]   r_src,      w_src_nxt;
  logic               r_sent,     w_sent_nxt;
  logic [SRC_W-1:0]   r_sent_src, w_sent_src_nxt;
  logic [SRC_W-1:0]   r_rr_ptr,   w_rr_ptr_nxt;
  logic [15:0]        r_cnt,      w_cnt_nxt;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_eligible;
  logic [NUM_IRQ-1:0] w_clr;
  logic               w_arb_valid;
  logic [SRC_W-1:0]   w_arb_idx;

  assign w_rise     = i_irq_in & ~r_irq_q;
  assign w_eligible = r_pending & ~i_irq_mask;

  pcie_msi_irq_ctrl_rr_arb #(
    .NUM_IRQ (NUM_IRQ)
  ) u_rr_arb (
    .i_req   (w_eligible),
    .i_last  (r_rr_ptr),
    .o_valid (w_arb_valid),
    .o_idx   (w_arb_idx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_irq_q    <= '0;
      r_pending  <= '0;
      r_request  <= 1'b0;
      r_vector   <= '0;
      r_src      <= '0;
      r_sent     <= 1'b0;
      r_sent_src <= '0;
      r_rr_ptr   <= RrInit;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_irq_q    <= i_irq_in;
      r_pending  <= w_pending_nxt;
      r_request  <= w_request_nxt;
      r_vector   <= w_vector_nxt;
      r_src      <= w_src_nxt;
      r_sent     <= w_sent_nxt;
      r_sent_src <= w_sent_src_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_request_nxt  = r_request;
    w_vector_nxt   = r_vector;
    w_src_nxt      = r_src;
    w_sent_nxt     = 1'b0;
    w_sent_src_nxt = r_sent_src;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_cnt_nxt      = r_cnt;
    w_clr          = '0;

    case (r_state)
      StIdle: begin
        if (i_msi_enable && w_arb_valid) begin
          w_state_nxt   = StReq;
          w_request_nxt = 1'b1;
          w_vector_nxt  = fold_vector(w_arb_idx, i_msi_vector_width);
          w_src_nxt     = w_arb_idx;
        end
      end
      // Held until granted; enable and mask changes never withdraw a request.
      StReq: begin
        if (i_intx_msi_grant) begin
          w_request_nxt  = 1'b0;
          w_sent_nxt     = 1'b1;
          w_sent_src_nxt = r_src;
          w_rr_ptr_nxt   = r_src;
          for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (SRC_W'(i) == r_src) w_clr[i] = 1'b1;
          end
          if (HOLDOFF_CYCLES != 0) begin
            w_state_nxt = StGap;
            w_cnt_nxt   = HoldLoad;
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      StGap: begin
        if (r_cnt == 16'd0) begin
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // A new edge on the source being granted re-arms it.
    w_pending_nxt = (r_pending & ~w_clr) | w_rise;
  end

  assign o_intx_msi_request = r_request;
  assign o_msi_vector_num   = r_vector;
  assign o_irq_pending      = r_pending;
  assign o_irq_sent         = r_sent;
  assign o_irq_sent_src     = r_sent_src;

endmodule

// File: tb/tb_pcie_msi_irq_ctrl.sv
// Directed bench for pcie_msi_irq_ctrl: one instance without holdoff, one with a
// ten-cycle holdoff gap.
module tb_pcie_msi_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] irq, mask, pend;
  logic       en, grant, req, sent;
  logic [2:0] width;
  logic [4:0] vec, ssrc;

  logic [7:0] irq1, mask1, pend1;
  logic       en1, grant1, req1, sent1;
  logic [2:0] width1;
  logic [4:0] vec1, ssrc1;

  int n_checks = 0;
  int n_fail   = 0;

  pcie_msi_irq_ctrl #(
    .NUM_IRQ        (8),
    .HOLDOFF_CYCLES (0)
  ) dut0 (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_irq_in           (irq),
    .i_irq_mask         (mask),
    .i_msi_enable       (en),
    .i_msi_vector_width (width),
    .i_intx_msi_grant   (grant),
    .o_intx_msi_request (req),
    .o_msi_vector_num   (vec),
    .o_irq_pending      (pend),
    .o_irq_sent         (sent),
    .o_irq_sent_src     (ssrc)
  );

  pcie_msi_irq_ctrl #(
    .NUM_IRQ        (8),
    .HOLDOFF_CYCLES (10)
  ) dut1 (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_irq_in           (irq1),
    .i_irq_mask         (mask1),
    .i_msi_enable       (en1),
    .i_msi_vector_width (width1),
    .i_intx_msi_grant   (grant1),
    .o_intx_msi_request (req1),
    .o_msi_vector_num   (vec1),
    .o_irq_pending      (pend1),
    .o_irq_sent         (sent1),
    .o_irq_sent_src     (ssrc1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant_now();
    grant = 1'b1;
    tick();
    grant = 1'b0;
  endtask

  task automatic grant1_now();
    grant1 = 1'b1;
    tick();
    grant1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    irq = '0; mask = '0; en = 1'b1; width = 3'd3; grant = 1'b0;
    irq1 = '0; mask1 = '0; en1 = 1'b1; width1 = 3'd3; grant1 = 1'b0;

    // Reset state
    tick();
    check_eq("rst_req",  32'(req),  0);
    check_eq("rst_vec",  32'(vec),  0);
    check_eq("rst_pend", 32'(pend), 0);
    check_eq("rst_sent", 32'(sent), 0);
    check_eq("rst_ssrc", 32'(ssrc), 0);
    rst = 1'b0;

    // 1: single source, grant 3 cycles after request
    irq = 8'h20;
    tick();
    irq = '0;
    check_eq("t1_pend",    32'(pend), 32'h20);
    check_eq("t1_req_lat", 32'(req),  0);
    tick();
    check_eq("t1_req",  32'(req), 1);
    check_eq("t1_vec",  32'(vec), 5);
    tick();
    tick();
    check_eq("t1_hold", 32'(req), 1);
    grant_now();
    check_eq("t1_req_drop", 32'(req),  0);
    check_eq("t1_sent",     32'(sent), 1);
    check_eq("t1_ssrc",     32'(ssrc), 5);
    check_eq("t1_pend_clr", 32'(pend), 0);
    tick();
    check_eq("t1_sent_pulse", 32'(sent), 0);

    // 2: round robin 1,3,6 then 7,1; grant while idle ignored
    do_reset();
    grant_now();
    check_eq("t2_idle_grant", 32'(sent), 0);
    irq = 8'h4A;
    tick();
    irq = '0;
    check_eq("t2_pend", 32'(pend), 32'h4A);
    tick();
    check_eq("t2_vec_a", 32'(vec), 1);
    grant_now();
    check_eq("t2_gap",    32'(req),  0);
    check_eq("t2_ssrc_a", 32'(ssrc), 1);
    check_eq("t2_pend_a", 32'(pend), 32'h48);
    tick();
    check_eq("t2_req_b", 32'(req), 1);
    check_eq("t2_vec_b", 32'(vec), 3);
    grant_now();
    check_eq("t2_ssrc_b", 32'(ssrc), 3);
    tick();
    check_eq("t2_vec_c", 32'(vec), 6);
    irq = 8'h82;
    grant_now();
    irq = '0;
    check_eq("t2_ssrc_c", 32'(ssrc), 6);
    check_eq("t2_pend_c", 32'(pend), 32'h82);
    tick();
    check_eq("t2_vec_wrap7", 32'(vec), 7);
    grant_now();
    tick();
    check_eq("t2_vec_wrap1", 32'(vec), 1);
    grant_now();
    check_eq("t2_ssrc_e", 32'(ssrc), 1);
    check_eq("t2_pend_e", 32'(pend), 0);

    // 3: vector fold
    width = 3'd1;
    irq = 8'h40;
    tick();
    irq = '0;
    tick();
    check_eq("t3_fold2", 32'(vec), 1);
    grant_now();
    width = 3'd6;
    irq = 8'h40;
    tick();
    irq = '0;
    tick();
    check_eq("t3_fold_rsvd", 32'(vec), 0);
    grant_now();
    width = 3'd3;
    tick();

    // 4: disabled, coalesced events, then enable
    en = 1'b0;
    irq = 8'h04;
    tick();
    irq = '0;
    tick();
    irq = 8'h04;
    tick();
    irq = '0;
    tick();
    tick();
    check_eq("t4_no_req", 32'(req),  0);
    check_eq("t4_pend",   32'(pend), 32'h04);
    en = 1'b1;
    tick();
    check_eq("t4_req", 32'(req), 1);
    check_eq("t4_vec", 32'(vec), 2);
    grant_now();
    check_eq("t4_pend_clr", 32'(pend), 0);
    tick();
    tick();
    check_eq("t4_single", 32'(req), 0);

    // 6: reset mid-request, held source at release, masking
    irq = 8'h01;
    tick();
    irq = '0;
    tick();
    check_eq("t6_req_pre", 32'(req), 1);
    #1 rst = 1'b1;
    #1;
    check_eq("t6_async_req",  32'(req),  0);
    check_eq("t6_async_pend", 32'(pend), 0);
    irq = 8'h08;
    tick();
    rst = 1'b0;
    tick();
    check_eq("t6_held_pend", 32'(pend), 32'h08);
    tick();
    check_eq("t6_held_vec", 32'(vec), 3);
    grant_now();
    tick();
    tick();
    check_eq("t6_held_once", 32'(req),  0);
    check_eq("t6_held_pend0", 32'(pend), 0);
    irq = '0;
    mask = 8'h10;
    irq = 8'h10;
    tick();
    irq = '0;
    tick();
    tick();
    check_eq("t6_mask_pend", 32'(pend), 32'h10);
    check_eq("t6_mask_req",  32'(req),  0);
    mask = '0;
    tick();
    check_eq("t6_unmask_req", 32'(req), 1);
    check_eq("t6_unmask_vec", 32'(vec), 4);
    grant_now();
    check_eq("t6_unmask_ssrc", 32'(ssrc), 4);

    // 5: holdoff gap of 10 on dut1, re-edge during grant
    irq1 = 8'h06;
    tick();
    irq1 = '0;
    tick();
    check_eq("t5_vec_a", 32'(vec1), 1);
    irq1 = 8'h02;
    grant1_now();
    irq1 = '0;
    check_eq("t5_ssrc_a",   32'(ssrc1), 1);
    check_eq("t5_pend_set", 32'(pend1), 32'h06);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t5_gap_a", 32'(req1), 0);
    end
    tick();
    check_eq("t5_req_b", 32'(req1), 1);
    check_eq("t5_vec_b", 32'(vec1), 2);
    grant1_now();
    check_eq("t5_ssrc_b", 32'(ssrc1), 2);
    check_eq("t5_pend_b", 32'(pend1), 32'h02);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t5_gap_b", 32'(req1), 0);
    end
    tick();
    check_eq("t5_req_c", 32'(req1), 1);
    check_eq("t5_vec_c", 32'(vec1), 1);
    grant1_now();
    check_eq("t5_pend_c", 32'(pend1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
